// File: rtl/rpm_pkg.sv
// Shared types and defaults for the multi-channel gated RPM meter.
package rpm_pkg;

   // Conversion sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } rpm_state_e;

   localparam int DEF_N_CH          = 3;
   localparam int DEF_CNT_W         = 8;
   localparam int DEF_COUNT_MAX     = 200;
   localparam int DEF_RPM_W         = 10;
   localparam int DEF_RPM_PER_COUNT = 4;
   localparam int DEF_GATE_CYCLES   = 50_000_000;

   // Width that holds count * scale without loss (unsigned)
   function automatic int prod_width(input int cnt_w, input int scale);
      return cnt_w + $clog2(scale + 1);
   endfunction

endpackage

// File: rtl/hall_edge_det.sv
// Two-flop synchroniser and rising-edge detector for one Hall/tach input.
module hall_edge_det
   import rpm_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_hall,
   output logic o_edge
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync_d;

   // Bring the asynchronous input into the clock domain and keep one delayed copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync1  <= i_hall;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   // One-cycle pulse per synchronised rising edge
   assign o_edge = r_sync2 & ~r_sync_d;

endmodule

// File: rtl/rpm_meter.sv
// Gated edge counting per channel, snapshot on the terminal gate cycle,
// then a sequential count-to-RPM conversion with saturation and a valid strobe.
module rpm_meter
   import rpm_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int COUNT_MAX     = DEF_COUNT_MAX,
   parameter int RPM_W         = DEF_RPM_W,
   parameter int RPM_PER_COUNT = DEF_RPM_PER_COUNT,
   parameter int GATE_CYCLES   = DEF_GATE_CYCLES
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [N_CH-1:0]         hall_in,
   output logic [N_CH*RPM_W-1:0]   rpm_out,
   output logic                    rpm_valid,
   output logic [N_CH-1:0]         ovf
);

   localparam int PROD_W  = prod_width(CNT_W, RPM_PER_COUNT);
   localparam int CMP_W   = (PROD_W > RPM_W) ? PROD_W : RPM_W + 1;
   localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RPM_MAX = (1 << RPM_W) - 1;

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(COUNT_MAX);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

   logic [N_CH-1:0]        w_edge;
   logic [GATE_W-1:0]      r_gate_cnt;
   logic                   w_term;
   logic [CNT_W-1:0]       r_edge_cnt [N_CH];
   logic [CNT_W-1:0]       r_snap_cnt [N_CH];
   logic [N_CH-1:0]        r_snap_sat;

   rpm_state_e             r_state;
   rpm_state_e             w_state_nxt;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic                   w_wr;
   logic                   w_last;

   logic [PROD_W-1:0]      w_prod;
   logic                   w_over;
   logic [RPM_W-1:0]       w_rpm;

   logic [N_CH*RPM_W-1:0]  r_rpm;
   logic [N_CH-1:0]        r_ovf;
   logic                   r_valid;

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : g_ch
         hall_edge_det u_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_hall (hall_in[g]),
            .o_edge (w_edge[g])
         );
      end
   endgenerate

   assign w_term = en && (r_gate_cnt == GATE_LAST);

   // Gate window counter: free-runs 0..GATE_CYCLES-1 while enabled, parked at 0 otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate_cnt <= {GATE_W{1'b0}};
      end else if (!en || w_term) begin
         r_gate_cnt <= {GATE_W{1'b0}};
      end else begin
         r_gate_cnt <= r_gate_cnt + GATE_W'(1);
      end
   end

   // Per-channel saturating edge counters; an edge on the terminal cycle opens the new window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) r_edge_cnt[i] <= {CNT_W{1'b0}};
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!en) begin
               r_edge_cnt[i] <= {CNT_W{1'b0}};
            end else if (w_term) begin
               r_edge_cnt[i] <= w_edge[i] ? CNT_W'(1) : {CNT_W{1'b0}};
            end else if (w_edge[i] && (r_edge_cnt[i] < CNT_SAT)) begin
               r_edge_cnt[i] <= r_edge_cnt[i] + CNT_W'(1);
            end else begin
               r_edge_cnt[i] <= r_edge_cnt[i];
            end
         end
      end
   end

   // Capture the closing window's counts and saturation flags on the terminal cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) r_snap_cnt[i] <= {CNT_W{1'b0}};
         r_snap_sat <= {N_CH{1'b0}};
      end else if (w_term) begin
         for (int i = 0; i < N_CH; i++) begin
            r_snap_cnt[i] <= r_edge_cnt[i];
            r_snap_sat[i] <= (r_edge_cnt[i] >= CNT_SAT);
         end
      end else begin
         r_snap_sat <= r_snap_sat;
      end
   end

   // Scale the selected channel's count and clamp to the RPM range before truncating
   always_comb begin
      w_prod = PROD_W'(r_snap_cnt[r_idx]) * PROD_W'(RPM_PER_COUNT);
      w_over = (CMP_W'(w_prod) > CMP_W'(RPM_MAX));
      if (w_over) begin
         w_rpm = {RPM_W{1'b1}};
      end else begin
         w_rpm = RPM_W'(w_prod);
      end
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= {IDX_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Sequencer next state: one channel per CONV cycle, then a single DONE cycle
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr        = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_term) begin
               w_state_nxt = ST_CONV;
               w_idx_nxt   = {IDX_W{1'b0}};
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CONV: begin
            w_wr = 1'b1;
            if (r_idx == IDX_LAST) begin
               w_last      = 1'b1;
               w_state_nxt = ST_DONE;
               w_idx_nxt   = {IDX_W{1'b0}};
            end else begin
               w_idx_nxt   = r_idx + IDX_W'(1);
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Result registers: slice and overflow bit of the channel being converted, plus the strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rpm   <= {(N_CH*RPM_W){1'b0}};
         r_ovf   <= {N_CH{1'b0}};
         r_valid <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_wr && (r_idx == IDX_W'(i))) begin
               r_rpm[i*RPM_W +: RPM_W] <= w_rpm;
               r_ovf[i]                <= r_snap_sat[i];
            end
         end
         r_valid <= w_last;
      end
   end

   assign rpm_out   = r_rpm;
   assign ovf       = r_ovf;
   assign rpm_valid = r_valid;

endmodule

// File: tb/tb_rpm_meter.sv
// Directed self-checking bench for rpm_meter with a 1000-cycle gate.
// Window cycle numbering: cycle 0 is the first cycle in which the gate counter
// reads 0 with en high; the terminal cycle is 999 and rpm_valid is expected in
// cycle 3 of the following window (T+4).
module tb_rpm_meter;

   localparam int N_CH  = 3;
   localparam int RPM_W = 10;
   localparam int GATE  = 1000;

   logic                  clk;
   logic                  rst_n;
   logic                  en;
   logic [N_CH-1:0]       hall_in;
   logic [N_CH*RPM_W-1:0] rpm_out;
   logic                  rpm_valid;
   logic [N_CH-1:0]       ovf;

   int total;
   int bad;
   int first_v;
   int vcnt;
   logic [N_CH*RPM_W-1:0] cap_rpm;
   logic [N_CH-1:0]       cap_ovf;

   rpm_meter #(
      .N_CH        (N_CH),
      .GATE_CYCLES (GATE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .hall_in   (hall_in),
      .rpm_out   (rpm_out),
      .rpm_valid (rpm_valid),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int a0, input int a1, input int a2);
      return (32'(a2) << 20) | (32'(a1) << 10) | 32'(a0);
   endfunction

   // Drive window cycles c0..c_end-1; channel i gets n[i] pulses of period per from cycle 20,
   // plus an optional extra ch0 pulse at cycle extra.
   task automatic drive(input int c0, input int c_end, input int n0, input int n1,
                        input int n2, input int per, input int extra);
      int n [N_CH];
      n[0] = n0; n[1] = n1; n[2] = n2;
      for (int c = c0; c < c_end; c++) begin
         for (int i = 0; i < N_CH; i++) begin
            hall_in[i] = (c >= 20) && (c < 20 + n[i] * per) && (((c - 20) % per) == 0);
         end
         if (c == extra) hall_in[0] = 1'b1;
         tick();
      end
      hall_in = '0;
   endtask

   // Watch ncyc cycles starting at the current one; record first strobe cycle and strobe count
   task automatic observe(input int ncyc);
      first_v = -1;
      vcnt    = 0;
      for (int k = 0; k < ncyc; k++) begin
         if (rpm_valid === 1'b1) begin
            if (first_v < 0) first_v = k;
            vcnt++;
            cap_rpm = rpm_out;
            cap_ovf = ovf;
         end
         tick();
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      en      = 1'b0;
      hall_in = '0;
      cap_rpm = '0;
      cap_ovf = '0;

      // Reset with hall inputs toggling
      for (int k = 0; k < 8; k++) begin
         hall_in = ~hall_in;
         tick();
      end
      chk("rst_rpm",   {2'b00, rpm_out}, 32'd0);
      chk("rst_valid", {31'd0, rpm_valid}, 32'd0);
      chk("rst_ovf",   {29'd0, ovf}, 32'd0);
      hall_in = '0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      // Nominal window: 25 / 0 / 50 edges
      en = 1'b1;
      drive(0, GATE, 25, 0, 50, 2, -1);
      observe(11);
      chk("nom_first_valid", first_v, 32'd3);
      chk("nom_valid_width", vcnt, 32'd1);
      chk("nom_rpm",         {2'b00, cap_rpm}, pk(100, 0, 200));
      chk("nom_ovf",         {29'd0, cap_ovf}, 32'd0);

      // Saturation: 300 edges on ch1 at period 3
      drive(11, GATE, 0, 300, 0, 3, -1);
      observe(11);
      chk("sat_first_valid", first_v, 32'd3);
      chk("sat_rpm",         {2'b00, cap_rpm}, pk(0, 800, 0));
      chk("sat_ovf",         {29'd0, cap_ovf}, 32'd2);

      // Recovery window: 10 edges on ch1
      drive(11, GATE, 0, 10, 0, 2, -1);
      observe(11);
      chk("rec_rpm", {2'b00, cap_rpm}, pk(0, 40, 0));
      chk("rec_ovf", {29'd0, cap_ovf}, 32'd0);

      // Boundary: 4 edges plus one whose pulse lands on the terminal cycle
      drive(11, GATE, 4, 0, 0, 2, 997);
      observe(11);
      chk("bnd_close_rpm", {2'b00, cap_rpm}, pk(16, 0, 0));
      drive(11, GATE, 2, 0, 0, 2, -1);
      observe(11);
      chk("bnd_next_rpm", {2'b00, cap_rpm}, pk(12, 0, 0));

      // Enable dropped mid-window; edges while disabled must be ignored
      drive(11, 500, 5, 0, 0, 2, -1);
      en   = 1'b0;
      vcnt = 0;
      for (int k = 0; k < 1200; k++) begin
         hall_in[0] = (k < 12) && ((k % 2) == 0);
         if (rpm_valid === 1'b1) vcnt++;
         tick();
      end
      hall_in = '0;
      chk("dis_no_valid", vcnt, 32'd0);
      chk("dis_rpm_hold", {2'b00, rpm_out}, pk(12, 0, 0));
      chk("dis_ovf_hold", {29'd0, ovf}, 32'd0);
      en = 1'b1;
      drive(0, GATE, 7, 0, 0, 2, -1);
      observe(11);
      chk("reen_first_valid", first_v, 32'd3);
      chk("reen_valid_width", vcnt, 32'd1);
      chk("reen_rpm",         {2'b00, cap_rpm}, pk(28, 0, 0));

      // Reset asserted at T+2 in the middle of the conversion pass
      drive(11, GATE, 9, 0, 3, 2, -1);
      tick();
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      chk("mid_rst_rpm",   {2'b00, rpm_out}, 32'd0);
      chk("mid_rst_ovf",   {29'd0, ovf}, 32'd0);
      chk("mid_rst_valid", {31'd0, rpm_valid}, 32'd0);
      vcnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (k == 5) rst_n = 1'b1;
         if (rpm_valid === 1'b1) vcnt++;
         tick();
      end
      chk("mid_rst_no_valid", vcnt, 32'd0);
      en = 1'b1;
      drive(0, GATE, 0, 0, 11, 2, -1);
      observe(11);
      chk("post_rst_first_valid", first_v, 32'd3);
      chk("post_rst_rpm",         {2'b00, cap_rpm}, pk(0, 0, 44));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
